// File: rtl/scmp_bus_pak.sv
// SC/MP bus target shared types.
// State encoding, status-flag bit positions and address type.
package scmp_bus_pak;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    RD_WAIT,
    RD_STRETCH,
    RD_DRIVE,
    WR_WAIT,
    WR_STRETCH,
    WR_END,
    DRAIN
  } BUS_STATE_t;

  localparam int FLG_IX_R = 0;
  localparam int FLG_IX_I = 1;
  localparam int FLG_IX_D = 2;
  localparam int FLG_IX_H = 3;

  typedef logic [15:0] BUS_ADDR_t;

endpackage

// File: rtl/scmp_bus_waitgen.sv
// Loadable 4-bit down-counter with zero flag.
// Times the bus_hold stretch after a memory ack.
module scmp_bus_waitgen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/scmp_bus_target.sv
// SC/MP external bus responder: latches address/status,
// runs a req/ack memory access and stretches the CPU cycle.
module scmp_bus_target
  import scmp_bus_pak::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ADS_n,
  input  logic        bus_RD_n,
  input  logic        bus_WR_n,
  input  logic [11:0] bus_ad,
  input  logic [7:0]  bus_db_in,
  output logic [7:0]  bus_db_out,
  output logic        bus_db_oe,
  output logic        bus_hold,
  output logic [15:0] cyc_addr,
  output logic [3:0]  cyc_flags,
  output logic        halt_pulse,
  output logic        proto_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  BUS_STATE_t state_q, state_d;
  BUS_ADDR_t  addr_q, addr_d;
  logic [3:0] flags_q, flags_d;
  logic       halt_q, halt_d;
  logic       perr_q, perr_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       hold_q, hold_d;
  logic       abort_q, abort_d;
  logic       do_lat;
  logic       wt_load;
  logic       wt_dec;
  logic       wt_zero;

  scmp_bus_waitgen u_wait (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (wt_load),
    .val_i  (4'(WAIT_STATES)),
    .dec_i  (wt_dec),
    .zero_o (wt_zero)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    flags_d = flags_q;
    halt_d  = 1'b0;
    perr_d  = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    hold_d  = hold_q;
    abort_d = abort_q;
    do_lat  = 1'b0;
    wt_load = 1'b0;
    wt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus_ADS_n) do_lat = 1'b1;
        else if (!bus_RD_n || !bus_WR_n) perr_d = 1'b1;
      end
      ADDR: begin
        if (!bus_ADS_n) begin
          do_lat = 1'b1;
        end else if (!bus_RD_n && !bus_WR_n) begin
          perr_d  = 1'b1;
          state_d = DRAIN;
        end else if (!bus_RD_n) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          hold_d  = 1'b1;
          abort_d = 1'b0;
          perr_d  = ~flags_q[FLG_IX_R];
          state_d = RD_WAIT;
        end else if (!bus_WR_n) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          hold_d  = 1'b1;
          wdata_d = bus_db_in;
          perr_d  = flags_q[FLG_IX_R];
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus_RD_n) abort_d = 1'b1;
        if (mem_ack) begin
          req_d = 1'b0;
          // a withdrawn read still finishes on the memory side
          if (abort_q || bus_RD_n) begin
            hold_d  = 1'b0;
            state_d = IDLE;
          end else begin
            dout_d  = mem_rdata;
            wt_load = 1'b1;
            state_d = RD_STRETCH;
          end
        end
      end
      RD_STRETCH: begin
        if (wt_zero) begin
          hold_d  = 1'b0;
          oe_d    = 1'b1;
          state_d = RD_DRIVE;
        end else begin
          wt_dec = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (bus_RD_n) begin
          oe_d    = 1'b0;
          state_d = IDLE;
          if (!bus_ADS_n) do_lat = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          wt_load = 1'b1;
          state_d = WR_STRETCH;
        end
      end
      WR_STRETCH: begin
        if (wt_zero) begin
          hold_d  = 1'b0;
          state_d = WR_END;
        end else begin
          wt_dec = 1'b1;
        end
      end
      WR_END: begin
        if (bus_WR_n) state_d = IDLE;
      end
      DRAIN: begin
        if (bus_RD_n && bus_WR_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_lat) begin
      addr_d  = {bus_db_in[3:0], bus_ad};
      flags_d = bus_db_in[7:4];
      halt_d  = bus_db_in[4+FLG_IX_H];
      state_d = ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      flags_q <= '0;
      halt_q  <= 1'b0;
      perr_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      hold_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      flags_q <= flags_d;
      halt_q  <= halt_d;
      perr_q  <= perr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      hold_q  <= hold_d;
      abort_q <= abort_d;
    end
  end

  assign bus_db_out = dout_q;
  assign bus_db_oe  = oe_q;
  assign bus_hold   = hold_q;
  assign cyc_addr   = addr_q;
  assign cyc_flags  = flags_q;
  assign halt_pulse = halt_q;
  assign proto_err  = perr_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_scmp_bus_target.sv
// Bench: two targets (0 and 3 wait states) on one bus,
// checked against latency/status rules computed here.
module tb_scmp_bus_target;

  localparam int W3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ads_n, rd_n, wr_n;
  logic [11:0] ad;
  logic [7:0]  db_in;
  logic [7:0]  rdata;
  logic        ack;

  logic [7:0]  dbo0, dbo3, wd0, wd3;
  logic        oe0, oe3, hold0, hold3, halt0, halt3;
  logic        perr0, perr3, req0, req3, we0, we3;
  logic [15:0] ca0, ca3, ma0, ma3;
  logic [3:0]  fl0, fl3;
  logic [4:0]  s0, s3;

  int nc = 0;
  int nf = 0;

  always #5 clk = ~clk;

  scmp_bus_target #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst),
    .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
    .bus_ad(ad), .bus_db_in(db_in),
    .bus_db_out(dbo0), .bus_db_oe(oe0), .bus_hold(hold0),
    .cyc_addr(ca0), .cyc_flags(fl0),
    .halt_pulse(halt0), .proto_err(perr0),
    .mem_req(req0), .mem_we(we0), .mem_addr(ma0),
    .mem_wdata(wd0), .mem_rdata(rdata), .mem_ack(ack)
  );

  scmp_bus_target #(.WAIT_STATES(W3)) u3 (
    .clk(clk), .rst(rst),
    .bus_ADS_n(ads_n), .bus_RD_n(rd_n), .bus_WR_n(wr_n),
    .bus_ad(ad), .bus_db_in(db_in),
    .bus_db_out(dbo3), .bus_db_oe(oe3), .bus_hold(hold3),
    .cyc_addr(ca3), .cyc_flags(fl3),
    .halt_pulse(halt3), .proto_err(perr3),
    .mem_req(req3), .mem_we(we3), .mem_addr(ma3),
    .mem_wdata(wd3), .mem_rdata(rdata), .mem_ack(ack)
  );

  assign s0 = {req0, hold0, oe0, perr0, halt0};
  assign s3 = {req3, hold3, oe3, perr3, halt3};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    ad = '0; db_in = '0; rdata = '0; ack = 1'b0;
    cyc(); cyc();
    nc++;
    if ({s0, s3, dbo0, dbo3, ca0, ca3, fl0, fl3,
         we0, we3, ma0, ma3, wd0, wd3} !== '0) begin
      nf++;
      $display("FAIL reset: s0=%b s3=%b ca0=%h ca3=%h want all 0",
               s0, s3, ca0, ca3);
    end
    rst = 1'b0;
    cyc();
  endtask

  // One full bus cycle; expectations follow from the bus rules.
  task automatic do_txn(input bit rd, input logic [15:0] a,
                        input logic [3:0] fl, input logic [7:0] d,
                        input int dly, input bit chain,
                        input string nm);
    logic perr;
    logic [4:0] e0, e3;
    logic [15:0] na;
    perr = rd ? ~fl[0] : fl[0];
    ads_n = 1'b0; ad = a[11:0]; db_in = {fl, a[15:12]};
    cyc();
    nc++;
    if (ca0 !== a || ca3 !== a || fl0 !== fl || fl3 !== fl ||
        s0 !== {4'b0, fl[3]} || s3 !== {4'b0, fl[3]}) begin
      nf++;
      $display("FAIL %s ads: ca=%h/%h fl=%h/%h s=%b/%b want %h %h h=%b",
               nm, ca0, ca3, fl0, fl3, s0, s3, a, fl, fl[3]);
    end
    ads_n = 1'b1;
    if (rd) rd_n = 1'b0;
    else begin wr_n = 1'b0; db_in = d; end
    cyc();
    e0 = {2'b11, 1'b0, perr, 1'b0};
    nc++;
    if (s0 !== e0 || s3 !== e0 || we0 !== !rd || we3 !== !rd ||
        ma0 !== a || ma3 !== a ||
        (!rd && (wd0 !== d || wd3 !== d))) begin
      nf++;
      $display("FAIL %s req: s=%b/%b we=%b ma=%h wd=%h want %b %b %h %h",
               nm, s0, s3, we0, ma0, wd0, e0, !rd, a, d);
    end
    db_in = 8'($urandom);
    for (int i = 0; i < dly; i++) begin
      cyc();
      nc++;
      if (s0 !== 5'b11000 || s3 !== 5'b11000 ||
          we0 !== !rd || ma0 !== a || ma3 !== a ||
          (!rd && (wd0 !== d || wd3 !== d))) begin
        nf++;
        $display("FAIL %s hold-req: s=%b/%b ma=%h wd=%h want 11000",
                 nm, s0, s3, ma0, wd0);
      end
    end
    ack = 1'b1;
    rdata = rd ? d : 8'($urandom);
    cyc();
    ack = 1'b0;
    rdata = 8'($urandom);
    nc++;
    if (s0 !== 5'b01000 || s3 !== 5'b01000) begin
      nf++;
      $display("FAIL %s ack: s=%b/%b want 01000", nm, s0, s3);
    end
    for (int n = 1; n <= 4; n++) begin
      cyc();
      e0 = {2'b00, rd, 2'b00};
      e3 = {1'b0, n <= W3, rd && n > W3, 2'b00};
      nc++;
      if (s0 !== e0 || s3 !== e3) begin
        nf++;
        $display("FAIL %s stretch+%0d: s=%b/%b want %b/%b",
                 nm, n, s0, s3, e0, e3);
      end
      if (rd) begin
        nc++;
        if (dbo0 !== d || (n > W3 && dbo3 !== d)) begin
          nf++;
          $display("FAIL %s rdata+%0d: %h/%h want %h",
                   nm, n, dbo0, dbo3, d);
        end
      end
    end
    rd_n = 1'b1; wr_n = 1'b1;
    na = 16'($urandom);
    if (chain && rd) begin
      ads_n = 1'b0; ad = na[11:0]; db_in = {4'b0001, na[15:12]};
    end
    cyc();
    ads_n = 1'b1;
    nc++;
    if (s0 !== 5'b0 || s3 !== 5'b0 ||
        (chain && rd && (ca0 !== na || ca3 !== na))) begin
      nf++;
      $display("FAIL %s end: s=%b/%b ca=%h/%h want 0 (chain %h)",
               nm, s0, s3, ca0, ca3, na);
    end
  endtask

  task automatic test_read();
    do_txn(1'b1, 16'h1234, 4'h5, 8'hA5, 0, 1'b0, "read");
  endtask

  task automatic test_write();
    do_txn(1'b0, 16'hF00F, 4'h0, 8'h3C, 2, 1'b0, "write");
  endtask

  task automatic test_halt();
    do_txn(1'b0, {4'h0, 12'($urandom)}, 4'hE, 8'h77, 1, 1'b0,
           "halt");
  endtask

  task automatic test_rd_r0();
    do_txn(1'b1, 16'h8001, 4'h0, 8'h5E, 1, 1'b0, "rd_r0");
  endtask

  task automatic expect_idle(input string nm);
    rd_n = 1'b0;
    cyc();
    nc++;
    if (perr0 !== 1'b1 || perr3 !== 1'b1 || req0 || req3) begin
      nf++;
      $display("FAIL %s idle-strobe: perr=%b/%b req=%b/%b want 1 0",
               nm, perr0, perr3, req0, req3);
    end
    rd_n = 1'b1;
    cyc();
  endtask

  task automatic test_both_strobes();
    ads_n = 1'b0; ad = 12'h0AA; db_in = 8'h13;
    cyc();
    ads_n = 1'b1; rd_n = 1'b0; wr_n = 1'b0;
    cyc();
    nc++;
    if (s0 !== 5'b00010 || s3 !== 5'b00010) begin
      nf++;
      $display("FAIL both: s=%b/%b want 00010", s0, s3);
    end
    rd_n = 1'b1;
    cyc(); cyc();
    nc++;
    if (s0 !== 5'b0 || s3 !== 5'b0) begin
      nf++;
      $display("FAIL drain: s=%b/%b want 0", s0, s3);
    end
    wr_n = 1'b1;
    cyc();
    expect_idle("drain");
  endtask

  task automatic test_abort();
    ads_n = 1'b0; ad = 12'h456; db_in = 8'h17;
    cyc();
    ads_n = 1'b1; rd_n = 1'b0;
    cyc();
    rd_n = 1'b1;
    repeat (2) begin
      cyc();
      nc++;
      if (s0 !== 5'b11000 || s3 !== 5'b11000 ||
          ma0 !== 16'h7456) begin
        nf++;
        $display("FAIL abort-hold: s=%b/%b ma=%h want 11000 7456",
                 s0, s3, ma0);
      end
    end
    ack = 1'b1; rdata = 8'h5A;
    cyc();
    ack = 1'b0;
    repeat (3) begin
      nc++;
      if (s0 !== 5'b0 || s3 !== 5'b0) begin
        nf++;
        $display("FAIL abort-done: s=%b/%b want 0", s0, s3);
      end
      cyc();
    end
    expect_idle("abort");
  endtask

  task automatic test_reset_in_wait();
    ads_n = 1'b0; ad = 12'h321; db_in = 8'h19;
    cyc();
    ads_n = 1'b1; rd_n = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    nc++;
    if (s0 !== 5'b0 || s3 !== 5'b0 || ca0 !== 16'h0 ||
        ca3 !== 16'h0) begin
      nf++;
      $display("FAIL rst-wait: s=%b/%b ca=%h/%h want 0",
               s0, s3, ca0, ca3);
    end
    rst = 1'b0; rd_n = 1'b1;
    cyc();
    expect_idle("rst-wait");
  endtask

  task automatic test_random();
    bit rd;
    logic [3:0] fl;
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom);
      fl = 4'($urandom);
      if ($urandom_range(3) != 0) fl[0] = rd;
      do_txn(rd, 16'($urandom), fl, 8'($urandom),
             int'($urandom_range(3)), 1'($urandom), "rand");
    end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 16'hBEEF, 4'h1, 8'hC3, 0, 1'b1, "b2b-a");
    do_txn(1'b1, 16'h0101, 4'h9, 8'h3C, 1, 1'b1, "b2b-b");
    do_txn(1'b0, 16'h4242, 4'h2, 8'h99, 0, 1'b0, "b2b-c");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_halt();
    test_rd_r0();
    test_both_strobes();
    test_abort();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
